// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared types for the pipeline hazard controller
package pipeline_hazard_ctrl_pkg;

    // Widest register select an entry can hold; narrower selects are zero-extended.
    localparam int SB_REG_W = 8;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic                valid;
        logic [SB_REG_W-1:0] wsel;
        logic                regwrite;
        logic                load;
        logic                halt;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    // True when the entry will write register r; r0 is hard-wired and never produced.
    function automatic logic produces(sb_entry_t e, logic [SB_REG_W-1:0] r);
        return e.valid && e.regwrite && (e.wsel == r) && (r != '0);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: in-flight register-write tracker with load-use and forwarding comparators
module hazard_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int NLATCH  = 4,
    parameter int REG_W   = 5,
    parameter int MEM_STG = 2,
    parameter int FWD_W   = $clog2(NLATCH)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [NLATCH-1:1] adv,
    input  logic [NLATCH-1:1] squash,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_W-1:0]  id_wsel,
    input  logic              id_regwrite,
    input  logic              id_load,
    input  logic              id_halt,
    output logic              load_use,
    output logic              mem_halt,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b
);

    sb_entry_t           sb_q [1:NLATCH-1];
    sb_entry_t           sb_d [1:NLATCH-1];
    sb_entry_t           id_e;
    logic [SB_REG_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
    logic [SB_REG_W-1:0] id_rs_w, id_rt_w;
    logic                early_fwd;

    assign id_rs_w = SB_REG_W'(id_rs);
    assign id_rt_w = SB_REG_W'(id_rt);
    assign id_e    = '{valid: 1'b1, wsel: SB_REG_W'(id_wsel), regwrite: id_regwrite,
                       load: id_load, halt: id_halt};

    // Latch 1 takes the ID instruction (or a bubble), older entries shift; a disabled latch holds.
    always_comb begin
        sb_d    = sb_q;
        ex_rs_d = ex_rs_q;
        ex_rt_d = ex_rt_q;
        if (adv[1]) begin
            sb_d[1] = squash[1] ? SB_BUBBLE : id_e;
            ex_rs_d = squash[1] ? '0 : id_rs_w;
            ex_rt_d = squash[1] ? '0 : id_rt_w;
        end
        for (int k = 2; k < NLATCH; k++)
            if (adv[k]) sb_d[k] = squash[k] ? SB_BUBBLE : sb_q[k-1];
    end

    // Scoreboard and EX source registers; reset empties every entry.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 1; k < NLATCH; k++) sb_q[k] <= SB_BUBBLE;
            ex_rs_q <= '0;
            ex_rt_q <= '0;
        end else begin
            sb_q    <= sb_d;
            ex_rs_q <= ex_rs_d;
            ex_rt_q <= ex_rt_d;
        end
    end

    // A load sitting in EX whose result the ID instruction needs; halt reaching the memory stage.
    always_comb begin
        load_use = sb_q[1].load &&
                   ((id_use_rs && produces(sb_q[1], id_rs_w)) ||
                    (id_use_rt && produces(sb_q[1], id_rt_w)));
        mem_halt = sb_q[MEM_STG].valid && sb_q[MEM_STG].halt;
    end

    // Scan oldest to youngest so the youngest eligible producer overrides; loads forward only past MEM.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = NLATCH - 1; k >= 2; k--) begin
            if (produces(sb_q[k], ex_rs_q) && !(sb_q[k].load && k <= MEM_STG)) fwd_a = FWD_W'(k);
            if (produces(sb_q[k], ex_rt_q) && !(sb_q[k].load && k <= MEM_STG)) fwd_b = FWD_W'(k);
        end
    end

    // Flags a selected source that is a load whose data has not been read from memory yet.
    always_comb begin
        early_fwd = 1'b0;
        for (int k = 1; k <= MEM_STG; k++)
            if (sb_q[k].load && (int'(fwd_a) == k || int'(fwd_b) == k)) early_fwd = 1'b1;
    end

    a_no_early_load_fwd: assert property (@(posedge CLK) disable iff (!nRST) !early_fwd);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward controller with run, memory-wait and halt states
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int NLATCH      = 4,
    parameter int REG_W       = 5,
    parameter int RESOLVE_STG = 2,
    parameter int MEM_STG     = 2,
    parameter int FWD_W       = $clog2(NLATCH)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_W-1:0]  id_wsel,
    input  logic              id_regwrite,
    input  logic              id_load,
    input  logic              id_halt,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic              redirect,
    output logic              pc_en,
    output logic [NLATCH-1:0] lat_en,
    output logic [NLATCH-1:0] lat_flush,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
    output logic              halt
);

    // Latches 0..RESOLVE_STG hold instructions younger than a resolved branch.
    localparam logic [NLATCH-1:0] REDIRECT_FLUSH = NLATCH'((1 << (RESOLVE_STG + 1)) - 1);

    hz_state_t state_q, state_d;
    logic      dwait, load_use, mem_halt;

    assign dwait = (mem_ren || mem_wen) && !dhit;

    hazard_scoreboard #(
        .NLATCH  (NLATCH),
        .REG_W   (REG_W),
        .MEM_STG (MEM_STG),
        .FWD_W   (FWD_W)
    ) u_sb (
        .CLK         (CLK),
        .nRST        (nRST),
        .adv         (lat_en[NLATCH-1:1]),
        .squash      (lat_flush[NLATCH-1:1]),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_wsel     (id_wsel),
        .id_regwrite (id_regwrite),
        .id_load     (id_load),
        .id_halt     (id_halt),
        .load_use    (load_use),
        .mem_halt    (mem_halt),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b)
    );

    // State register; reset always returns to RUN.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= RUN;
        else       state_q <= state_d;
    end

    // HALTED is terminal; otherwise a halt leaving the memory stage wins unless memory is still busy.
    always_comb begin
        state_d = state_q;
        if (state_q != HALTED)
            state_d = dwait ? MEM_WAIT : (mem_halt ? HALTED : RUN);
    end

    // Enables and flushes, first matching rule wins: halted, data wait, redirect, load-use, fetch miss.
    always_comb begin
        pc_en     = 1'b1;
        lat_en    = '1;
        lat_flush = '0;
        halt      = 1'b0;
        if (state_q == HALTED) begin
            pc_en  = 1'b0;
            lat_en = '0;
            halt   = 1'b1;
        end else if (dwait) begin
            pc_en  = 1'b0;
            lat_en = '0;
        end else if (redirect) begin
            lat_flush = REDIRECT_FLUSH;
        end else if (load_use) begin
            pc_en        = 1'b0;
            lat_en[0]    = 1'b0;
            lat_flush[1] = 1'b1;
        end else if (!ihit) begin
            pc_en        = 1'b0;
            lat_flush[0] = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random stimulus against an instruction-level pipeline model
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    localparam int NL = 4;
    localparam int MS = 2;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       ihit = 1'b1, dhit = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, id_wsel = '0;
    logic       id_use_rs = 1'b0, id_use_rt = 1'b0;
    logic       id_regwrite = 1'b0, id_load = 1'b0, id_halt = 1'b0;
    logic       mem_ren = 1'b0, mem_wen = 1'b0, redirect = 1'b0;
    logic       pc_en, halt;
    logic [3:0] lat_en, lat_flush;
    logic [1:0] fwd_a, fwd_b;

    pipeline_hazard_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_wsel(id_wsel), .id_regwrite(id_regwrite), .id_load(id_load), .id_halt(id_halt),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .redirect(redirect),
        .pc_en(pc_en), .lat_en(lat_en), .lat_flush(lat_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halt(halt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit ihit, dhit, ren, wen, redir, urs, urt, rw, ld, hl;
        int rs, rt, wd;
    } in_t;

    typedef struct {
        bit     pc_en, hlt;
        bit [3:0] en, fl;
        int     fa, fb;
    } out_t;

    typedef struct {
        bit v, rw, ld, hl;
        int rs, rt, wd;
    } instr_t;

    instr_t pipe [1:NL-1];
    bit     m_halted;
    out_t   exp_q [$];
    int     checks = 0;
    int     errors = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endfunction

    function automatic in_t op(int rs, int rt, int wd, bit rw, bit ld, bit hl);
        in_t i = '{default: 0};
        i.ihit = 1; i.dhit = 1; i.urs = 1; i.urt = 1;
        i.rs = rs; i.rt = rt; i.wd = wd; i.rw = rw; i.ld = ld; i.hl = hl;
        return i;
    endfunction

    function automatic void model_reset();
        for (int k = 1; k < NL; k++) pipe[k] = '{default: 0};
        m_halted = 0;
    endfunction

    // Youngest older instruction whose result for r already exists; loads only once past MEM.
    function automatic int fwd_src(int r);
        if (r == 0 || !pipe[1].v) return 0;
        for (int k = 2; k < NL; k++)
            if (pipe[k].v && pipe[k].rw && pipe[k].wd == r && !(pipe[k].ld && k <= MS)) return k;
        return 0;
    endfunction

    function automatic out_t predict(in_t i);
        out_t o;
        bit lu;
        lu = pipe[1].v && pipe[1].ld && pipe[1].rw && pipe[1].wd != 0 &&
             ((i.urs && i.rs == pipe[1].wd) || (i.urt && i.rt == pipe[1].wd));
        o.pc_en = 1; o.en = 4'hF; o.fl = 4'h0; o.hlt = m_halted;
        o.fa = fwd_src(pipe[1].rs);
        o.fb = fwd_src(pipe[1].rt);
        if (m_halted) begin
            o.pc_en = 0; o.en = 4'h0;
        end else if ((i.ren || i.wen) && !i.dhit) begin
            o.pc_en = 0; o.en = 4'h0;
        end else if (i.redir) begin
            o.fl = 4'b0111;
        end else if (lu) begin
            o.pc_en = 0; o.en = 4'b1110; o.fl = 4'b0010;
        end else if (!i.ihit) begin
            o.pc_en = 0; o.fl = 4'b0001;
        end
        return o;
    endfunction

    function automatic void commit(in_t i, out_t o);
        if (!o.en[NL-1]) return;
        if (pipe[MS].v && pipe[MS].hl) m_halted = 1;
        for (int k = NL - 1; k > 1; k--) pipe[k] = pipe[k-1];
        pipe[1] = '{v: 1, rw: i.rw, ld: i.ld, hl: i.hl, rs: i.rs, rt: i.rt, wd: i.wd};
        for (int k = 1; k < NL; k++) if (o.fl[k]) pipe[k] = '{default: 0};
    endfunction

    task automatic drive(input in_t i, input bit rst);
        out_t o;
        @(posedge CLK);
        #1;
        ihit = i.ihit; dhit = i.dhit; mem_ren = i.ren; mem_wen = i.wen; redirect = i.redir;
        id_rs = 5'(i.rs); id_rt = 5'(i.rt); id_wsel = 5'(i.wd);
        id_use_rs = i.urs; id_use_rt = i.urt;
        id_regwrite = i.rw; id_load = i.ld; id_halt = i.hl;
        nRST = !rst;
        if (rst) model_reset();
        o = predict(i);
        exp_q.push_back(o);
        if (!rst) commit(i, o);
    endtask

    function automatic in_t rand_in();
        in_t i = '{default: 0};
        bit mem;
        mem     = ($urandom_range(0, 5) == 0);
        i.ihit  = ($urandom_range(0, 7) != 0);
        i.ren   = mem && ($urandom_range(0, 1) == 1);
        i.wen   = mem && !i.ren;
        i.dhit  = mem ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 1) == 1);
        i.redir = ($urandom_range(0, 9) == 0);
        i.rs    = $urandom_range(0, 5);
        i.rt    = $urandom_range(0, 5);
        i.wd    = $urandom_range(0, 5);
        i.urs   = ($urandom_range(0, 3) != 0);
        i.urt   = ($urandom_range(0, 3) != 0);
        i.rw    = ($urandom_range(0, 3) != 0);
        i.ld    = ($urandom_range(0, 2) == 0);
        i.hl    = ($urandom_range(0, 199) == 0);
        return i;
    endfunction

    // Monitor: every cycle's outputs against the expectation queued when the stimulus was issued.
    initial begin
        out_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_en", int'(pc_en), int'(e.pc_en));
                chk("lat_en", int'(lat_en), int'(e.en));
                chk("lat_flush", int'(lat_flush), int'(e.fl));
                chk("fwd_a", int'(fwd_a), e.fa);
                chk("fwd_b", int'(fwd_b), e.fb);
                chk("halt", int'(halt), int'(e.hlt));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        in_t nop;
        int  halt_cnt = 0;
        nop = op(0, 0, 0, 0, 0, 0);
        model_reset();
        drive(nop, 1);
        #1;
        chk("reset_pc_en", int'(pc_en), 1);
        chk("reset_lat_en", int'(lat_en), 15);
        chk("reset_halt", int'(halt), 0);
        drive(nop, 1);

        // lw r2 ; add r3,r2,r4 -> one stall cycle, then forward from MEM/WB
        drive(op(0, 0, 2, 1, 1, 0), 0);
        drive(op(2, 4, 3, 1, 0, 0), 0);
        #1;
        chk("lu_pc_en", int'(pc_en), 0);
        chk("lu_lat_en", int'(lat_en), 4'b1110);
        chk("lu_flush", int'(lat_flush), 4'b0010);
        drive(op(2, 4, 3, 1, 0, 0), 0);
        #1;
        chk("lu_release", int'(pc_en), 1);
        drive(nop, 0);
        #1;
        chk("lu_fwd_a", int'(fwd_a), 3);

        // add r5,r1,r1 ; sub r6,r5,r5 -> no stall, both operands from EX/MEM
        drive(op(1, 1, 5, 1, 0, 0), 0);
        drive(op(5, 5, 6, 1, 0, 0), 0);
        #1;
        chk("alu_no_stall", int'(pc_en), 1);
        drive(nop, 0);
        #1;
        chk("alu_fwd_a", int'(fwd_a), 2);
        chk("alu_fwd_b", int'(fwd_b), 2);

        // redirect with a fetch miss; the squashed ID load must not cause a later stall
        drive(op(1, 2, 7, 1, 0, 0), 0);
        begin
            in_t br;
            br = op(7, 7, 8, 1, 1, 0);
            br.redir = 1;
            br.ihit = 0;
            drive(br, 0);
        end
        #1;
        chk("br_pc_en", int'(pc_en), 1);
        chk("br_lat_en", int'(lat_en), 15);
        chk("br_flush", int'(lat_flush), 4'b0111);
        drive(op(8, 8, 9, 1, 0, 0), 0);
        #1;
        chk("br_no_stall", int'(pc_en), 1);

        // sw with dhit low for three cycles
        for (int n = 0; n < 4; n++) begin
            in_t sw;
            sw = nop;
            sw.wen = 1;
            sw.dhit = (n == 3);
            drive(sw, 0);
            #1;
            chk("sw_lat_en", int'(lat_en), n == 3 ? 15 : 0);
            if (n == 1 || n == 2) chk("sw_state", int'(dut.state_q), int'(MEM_WAIT));
        end

        // halt travels to EX/MEM, then the pipeline freezes until reset
        drive(op(0, 0, 0, 0, 0, 1), 0);
        drive(nop, 0);
        drive(nop, 0);
        #1;
        chk("halt_not_yet", int'(halt), 0);
        for (int n = 0; n < 11; n++) begin
            drive(nop, 0);
            #1;
            chk("halted_halt", int'(halt), 1);
            chk("halted_lat_en", int'(lat_en), 0);
            chk("halted_pc_en", int'(pc_en), 0);
        end
        drive(nop, 1);
        #1;
        chk("rst_halt", int'(halt), 0);
        chk("rst_pc_en", int'(pc_en), 1);

        // writes to r0 are never forwarded or stalled on
        drive(op(1, 1, 0, 1, 0, 0), 0);
        drive(op(0, 0, 0, 1, 1, 0), 0);
        #1;
        chk("r0_no_stall1", int'(pc_en), 1);
        drive(op(0, 0, 4, 1, 0, 0), 0);
        #1;
        chk("r0_no_stall2", int'(pc_en), 1);
        chk("r0_fwd_a", int'(fwd_a), 0);
        drive(nop, 0);
        #1;
        chk("r0_fwd_b", int'(fwd_b), 0);

        // random traffic, with resets after a halt and occasionally at arbitrary points
        for (int n = 0; n < 3000; n++) begin
            in_t i;
            bit  r;
            i = rand_in();
            r = (m_halted && halt_cnt > 12) || ($urandom_range(0, 299) == 0);
            drive(i, r);
            halt_cnt = m_halted ? halt_cnt + 1 : 0;
        end

        @(negedge CLK);
        @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Centralised hazard, stall, flush and forwarding controller for the in-order MIPS pipeline.
- Replaces per-latch ad-hoc dhit gating with one scoreboard of in-flight register writes plus a run/mem-wait/halt FSM.
- Drives enable/flush for every pipeline latch and forwarding selects for both EX operands.
- Generalised over pipeline depth, branch-resolve stage and register-address width.

Parameters:
- NLATCH, 4, number of pipeline latches; index 0 = IF/ID ... NLATCH-1 = MEM/WB.
- REG_W, 5, register-select width.
- RESOLVE_STG, 2, latch index whose output carries the resolved branch/jump (1 = ID/EX, 2 = EX/MEM).
- MEM_STG, 2, latch index whose output drives dmemREN/dmemWEN.
- FWD_W, $clog2(NLATCH), forwarding-select width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction fetch complete.
- dhit  in  1  data access complete.
- id_rs, id_rt  in  REG_W  source registers of the instruction in ID.
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs/rt.
- id_wsel  in  REG_W  destination register of the ID instruction.
- id_regwrite, id_load, id_halt  in  1  ID instruction writes a register / is lw / is halt.
- mem_ren, mem_wen  in  1  dmem request from latch MEM_STG.
- redirect  in  1  taken branch or jump at the output of latch RESOLVE_STG.
- pc_en  out  1  PC load enable.
- lat_en  out  NLATCH  per-latch load enable.
- lat_flush  out  NLATCH  per-latch synchronous clear to bubble; takes effect when lat_en=1.
- fwd_a, fwd_b  out  FWD_W  EX operand source: 0 = register file, k = output of latch k.
- halt  out  1  sticky processor halt.

Behaviour:
- Reset (async): FSM=RUN; all scoreboard entries invalid; ex_rs/ex_rt=0; halt=0. Outputs settle combinationally from that state: pc_en=lat_en=all-1, lat_flush=0, fwd=0.
- Scoreboard: entries sb[1..NLATCH-1], one per latch from ID/EX onward. Each entry holds {valid, wsel, regwrite, load, halt}. ex_rs/ex_rt are registered alongside sb[1].
- On an advance cycle:
  - sb[1] loads the ID fields, or a bubble when lat_flush[1] or a stall is active.
  - sb[k] <= sb[k-1].
- FSM states:
  - RUN: normal operation.
  - MEM_WAIT: entered when (mem_ren|mem_wen)&!dhit.
  - HALTED.
- Transitions:
  - RUN->MEM_WAIT on the condition above.
  - MEM_WAIT->RUN in the cycle dhit=1; that cycle advances normally.
  - Any->HALTED when sb[MEM_STG].valid&halt and the stage advances.
  - HALTED is left only by reset.
- Priority, highest first; each cycle obeys the first matching rule:
  1. HALTED: pc_en=0, lat_en=0, halt=1.
  2. Data wait ((mem_ren|mem_wen)&!dhit): pc_en=0, lat_en=0, scoreboard frozen.
  3. redirect: pc_en=1 (target loaded even if !ihit); lat_en=all-1; lat_flush[0..RESOLVE_STG]=1, so every younger instruction is squashed.
  4. Load-use (sb[1].valid&load&regwrite, wsel!=0, matching an ID source with its use bit set): pc_en=0, lat_en[0]=0, lat_flush[1]=1; older latches advance.
  5. !ihit: pc_en=0, lat_flush[0]=1, older latches advance.
  6. Otherwise everything advances.
- Forwarding:
  - fwd_a=k for the smallest k in 2..NLATCH-1 with sb[k].valid&regwrite&!load-at-k<MEM_STG+1 and wsel==ex_rs!=0; else 0. fwd_b is the same using ex_rt.
  - The youngest producer wins.
  - Register 0 is never forwarded or stalled on.
- Invariant (assert): no forward from a load entry whose data is not yet loaded.
- Simultaneous events:
  - redirect + load-use: redirect wins, stall suppressed.
  - halt in ID + redirect: halt is squashed.
  - dhit in the same cycle as redirect: rule 3 applies.
- Reset mid-stall or mid-wait: returns to RUN with the scoreboard empty.

Decomposition:
- cpu_types_pkg gains a sb_entry_t struct and an hz_state_t enum {RUN, MEM_WAIT, HALTED}.
- One sub-module, hazard_scoreboard: the shift register plus match/forward comparators.
- The FSM and enable logic live in the top.

Test Plan:
- lw r2 then add r3,r2,r4 (ihit=dhit=1) -> exactly one cycle with pc_en=0, lat_en[0]=0, lat_flush[1]=1; two cycles later fwd_a=3 (MEM/WB).
- add r5,r1,r1 then sub r6,r5,r5 -> no stall; fwd_a=fwd_b=2 while sub is in EX.
- Taken beq with redirect=1 and !ihit in the same cycle -> pc_en=1, lat_flush=0b0111, no stall; next ID instruction is not scoreboarded.
- sw with dhit held low 3 cycles -> lat_en=0 for 3 cycles, FSM=MEM_WAIT; all latches advance on the dhit cycle.
- halt reaches EX/MEM -> halt=1 next cycle; all enables 0 for 10 further cycles; nRST low mid-halt -> halt=0, pc_en=1 asynchronously.
- Writes to r0 followed by readers of r0 -> fwd_a=fwd_b=0, never stalls.
